// File: rtl/alu_pkg.sv
// Shared definitions for the signed ALU datapath: FSM state encoding and a
// compile-time ceiling-log2 used to size counters.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/csa_row.sv
// One W-bit adder/subtractor row built from single-bit full-adder cells.
// sub=1 inverts the addend and injects carry-in 1 (two's-complement subtract).
module csa_row #(
  parameter int W = 6
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  input  logic         en,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] addend_eff;
  logic [W:0]   carry;

  // A disabled row contributes nothing, so the subtract carry is gated too.
  assign addend_eff = en ? (sub ? ~addend : addend) : '0;
  assign carry[0]   = en & sub;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_cell
      assign sum[gi]      = acc[gi] ^ addend_eff[gi] ^ carry[gi];
      assign carry[gi+1]  = (acc[gi] & addend_eff[gi]) |
                            (acc[gi] & carry[gi]) |
                            (addend_eff[gi] & carry[gi]);
    end
  endgenerate

endmodule

// File: rtl/seq_signed_mult.sv
// Sequential two's-complement multiplier: one partial-product row per clock,
// the last (sign-weighted) row subtracted, result registered with a done pulse.
module seq_signed_mult
  import alu_pkg::*;
#(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p
);

  localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  p_q, p_d;

  logic [2*N-1:0]  addend;
  logic [2*N-1:0]  row_sum;
  logic            last_row;
  logic            row_en;

  assign last_row = (cnt_q == CW'(N-1));
  assign row_en   = b_q[cnt_q];
  assign addend   = {{N{a_q[N-1]}}, a_q} << cnt_q;

  csa_row #(.W(2*N)) u_row (
    .acc    (acc_q),
    .addend (addend),
    .en     (row_en),
    .sub    (last_row),
    .sum    (row_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = row_sum;
        cnt_d = cnt_q + 1'b1;
        if (last_row) begin
          p_d     = row_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign p    = p_q;

endmodule
